// File: rtl/sync_monitor_pkg.sv
// Shared types for the sync monitor: acquisition states, period classes,
// counter width and the period classifier.
package sync_monitor_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GOOD  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } class_t;

    // Period p is one bit wider than the counter so cnt+1 never wraps.
    function automatic class_t classify(
        input logic [CNT_W:0] p,
        input logic [CNT_W:0] lo,
        input logic [CNT_W:0] hi
    );
        if (p < lo) begin
            return SHORT;
        end
        if (p > hi) begin
            return LONG;
        end
        return GOOD;
    endfunction

endpackage

// File: rtl/sync_monitor_if.sv
// Sync monitor signal bundle: the sync line in, the strobes and status out.
// master drives sync_in, slave is the monitor itself.
interface sync_monitor_if;
    import sync_monitor_pkg::*;

    logic             sync_in;
    logic             edge_pulse;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             locked;
    logic             err_short;
    logic             err_long;
    logic [CNT_W-1:0] mark_cnt;

    modport master (
        output sync_in,
        input  edge_pulse, period, period_vld, locked,
        input  err_short, err_long, mark_cnt
    );

    modport slave (
        input  sync_in,
        output edge_pulse, period, period_vld, locked,
        output err_short, err_long, mark_cnt
    );

endinterface

// File: rtl/sync_monitor_edge.sv
// Rising-edge detector for the sync line. With SYNC_MONITOR_CDC_EN defined a
// 2-flop synchronizer (reset high) sits in front of the detector.
module sync_monitor_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sync,
    output logic o_rise
);

    logic w_sync;
    logic r_sync_d;

`ifdef SYNC_MONITOR_CDC_EN
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_sync;
            r_sync <= r_meta;
        end
    end

    assign w_sync = r_sync;
`else
    assign w_sync = i_sync;
`endif

    // Reset high so a line already high at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync_d <= 1'b1;
        end else begin
            r_sync_d <= w_sync;
        end
    end

    assign o_rise = w_sync & ~r_sync_d;

endmodule

// File: rtl/sync_monitor.sv
// Sync pulse monitor: period measurement, tolerance check, lock acquisition
// and mark counting. Input synchronizer enabled by SYNC_MONITOR_CDC_EN.
//
// state | meaning
// HUNT  | waiting for a reference edge, timeouts disabled
// ACQ   | measuring periods, counting consecutive good ones
// LOCK  | locked, good periods counted as marks
module sync_monitor
    import sync_monitor_pkg::*;
#(
    parameter int unsigned NOMINAL  = 48_000_000,
    parameter int unsigned TOL      = 48,
    parameter int unsigned LOCK_CNT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    sync_monitor_if.slave bus
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  LIM_HI   = CNT_W'(NOMINAL + TOL);
    localparam logic [CNT_W-1:0]  LIM_LO   = CNT_W'(NOMINAL - TOL);
    localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_CNT);

    logic              w_rise;
    logic              w_timeout;
    logic [CNT_W:0]    w_p;
    class_t            w_cls;
    logic [GOOD_W-1:0] w_good_inc;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [GOOD_W-1:0] r_good;
    logic [GOOD_W-1:0] w_good_nxt;
    logic [CNT_W-1:0]  r_period;
    logic [CNT_W-1:0]  w_period_nxt;
    logic [CNT_W-1:0]  r_mark;
    logic [CNT_W-1:0]  w_mark_nxt;
    logic              r_edge;
    logic              r_vld;
    logic              w_vld_nxt;
    logic              r_short;
    logic              w_short_nxt;
    logic              r_long;
    logic              w_long_nxt;
    logic              r_locked;

    sync_monitor_edge u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sync (bus.sync_in),
        .o_rise (w_rise)
    );

    assign w_p        = {1'b0, r_cnt} + (CNT_W + 1)'(1);
    assign w_cls      = classify(w_p, {1'b0, LIM_LO}, {1'b0, LIM_HI});
    assign w_timeout  = (r_state != HUNT) && (r_cnt == LIM_HI);
    assign w_good_inc = r_good + GOOD_W'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_good_nxt   = r_good;
        w_period_nxt = r_period;
        w_mark_nxt   = r_mark;
        w_vld_nxt    = 1'b0;
        w_short_nxt  = 1'b0;
        w_long_nxt   = 1'b0;

        if (w_rise) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == '1) begin
            w_cnt_nxt = r_cnt;
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end

        case (r_state)
            HUNT: begin
                if (w_rise) begin
                    w_state_nxt = ACQ;
                    w_good_nxt  = '0;
                end
            end
            ACQ, LOCK: begin
                // A rise coinciding with the timeout becomes the new reference.
                if (w_timeout) begin
                    w_long_nxt  = 1'b1;
                    w_good_nxt  = '0;
                    w_state_nxt = w_rise ? ACQ : HUNT;
                end else if (w_rise) begin
                    w_period_nxt = w_p[CNT_W-1:0];
                    w_vld_nxt    = 1'b1;
                    case (w_cls)
                        GOOD: begin
                            if (r_state == ACQ) begin
                                w_good_nxt = w_good_inc;
                                if (w_good_inc == GOOD_TGT) begin
                                    w_state_nxt = LOCK;
                                end
                            end else begin
                                w_mark_nxt = r_mark + CNT_W'(1);
                            end
                        end
                        SHORT: begin
                            w_short_nxt = 1'b1;
                            w_good_nxt  = '0;
                            w_state_nxt = ACQ;
                        end
                        default: begin
                            w_good_nxt  = '0;
                            w_state_nxt = ACQ;
                        end
                    endcase
                end
            end
            default: begin
                w_state_nxt = HUNT;
                w_good_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= HUNT;
            r_cnt    <= '0;
            r_good   <= '0;
            r_period <= '0;
            r_mark   <= '0;
            r_edge   <= 1'b0;
            r_vld    <= 1'b0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_good   <= w_good_nxt;
            r_period <= w_period_nxt;
            r_mark   <= w_mark_nxt;
            r_edge   <= w_rise;
            r_vld    <= w_vld_nxt;
            r_short  <= w_short_nxt;
            r_long   <= w_long_nxt;
            r_locked <= (w_state_nxt == LOCK);
        end
    end

    assign bus.edge_pulse = r_edge;
    assign bus.period     = r_period;
    assign bus.period_vld = r_vld;
    assign bus.locked     = r_locked;
    assign bus.err_short  = r_short;
    assign bus.err_long   = r_long;
    assign bus.mark_cnt   = r_mark;

endmodule

// File: doc/sync_monitor.md
# sync_monitor

Consumer of the periodic sync pulses produced by the sync generator stage (48 MHz domain). Detects rising edges on one sync line, measures the edge-to-edge period in clock cycles, and checks it against a nominal interval with tolerance. A three-state acquisition machine declares lock after enough consecutive good periods, and counts accepted marks (seconds when fed the 1 s sync).

## Interface
- NOMINAL, 48_000_000, expected period in clk cycles
- TOL, 48, allowed deviation (±cycles); must satisfy TOL < NOMINAL
- LOCK_CNT, 3, consecutive good periods required to lock; ≥1
- clk  input  1  system clock (48 MHz)
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- sync_in  input  1  sync pulse (pulse width ≥1 cycle)
- edge_pulse  output  1  one-cycle strobe per detected rising edge
- period  output  32  last measured period (cycles)
- period_vld  output  1  one-cycle strobe when period updates
- locked  output  1  high in LOCK state
- err_short  output  1  one-cycle strobe: period < NOMINAL-TOL
- err_long  output  1  one-cycle strobe: no edge by NOMINAL+TOL cycles
- mark_cnt  output  32  count of edges accepted while locked

## Operation
- Edge detect: rise = sync_in & ~sync_d; sync_d is the previous sample, reset value 1 (a high level at reset release is not an edge).
- cnt (32 b): cleared to 0 on every rise, otherwise increments, saturating at 2^32-1. Measured p = cnt+1.
- States: HUNT, ACQ, LOCK; good counter (width clog2(LOCK_CNT+1)).
- HUNT: rise → ACQ, good=0, no period_vld.
- ACQ/LOCK rise: period<=p, period_vld=1. Good if NOMINAL-TOL ≤ p ≤ NOMINAL+TOL.
  - ACQ good: good+1; reaching LOCK_CNT → LOCK.
  - ACQ short: err_short, good=0, stay ACQ.
  - LOCK good: mark_cnt+1 (wraps at 2^32).
  - LOCK short: err_short, → ACQ, good=0.
- Timeout: in ACQ/LOCK, when cnt == NOMINAL+TOL and no rise → err_long, → HUNT. Fires once; cnt keeps counting.
- Simultaneous timeout and rise (p = NOMINAL+TOL+1): err_long, no period_vld, → ACQ, good=0, cnt=0 (the edge becomes the new reference).
- In HUNT, timeouts do not fire.
- Reset: state HUNT, cnt=0, good=0, all outputs 0, mark_cnt=0, period=0, sync_d=1.

## Timing
- All outputs registered. Edge sampled at posedge k → edge_pulse, period/period_vld, err_short, state/locked updates visible after posedge k (1-cycle latency).
- err_long is asserted after the posedge at which cnt == NOMINAL+TOL was sampled.
- locked rises in the same cycle as the period_vld of the LOCK_CNT-th good period, and falls with err_short/err_long.
- Strobes are never wider than one cycle. A level held high produces one edge_pulse.

## Configuration
- SYNC_MONITOR_CDC_EN defined: sync_in passes through a 2-flop synchronizer (reset 1) before edge detect. Latency from sync_in to all outputs becomes 3 cycles; periods are unchanged.
- Undefined: sync_in is sampled directly, because it must be synchronous to clk. Latency is 1 cycle.

## Structure
- Package sync_monitor_pkg: state enum typedef (HUNT/ACQ/LOCK), counter width constant (32), and a period-classification enum (GOOD/SHORT/LONG).
- Sub-module sync_monitor_edge: optional synchronizer plus edge detector, outputting rise. The FSM, counters and classification stay in the top module.

## Test plan
All tests use NOMINAL=100, TOL=2, LOCK_CNT=3, macro undefined unless stated.
- Rises every 100 cycles, ×6 → no period_vld on rise 1; period=100 on rises 2–6; locked high after rise 4; mark_cnt=2 after rise 6.
- Locked, next rise after 97 cycles → err_short pulse, period=97, locked drops. Rise after 98 cycles in a separate run → accepted, mark_cnt+1.
- Locked, pulse omitted → err_long exactly once, 103 cycles after last rise's posedge, locked=0, state HUNT. Next rise: no period_vld.
- Rise exactly 103 cycles after previous → err_long, no period_vld, state ACQ. Rise 100 cycles later gives period_vld with period=100.
- sync_in high for 26 cycles per pulse → one edge_pulse per pulse. Assert rst_n=0 mid-lock with sync_in high, release while high → all outputs 0, no edge_pulse until next low→high.
- SYNC_MONITOR_CDC_EN defined, first test repeated → identical periods/lock sequence, each strobe delayed 2 cycles.
